// File: rtl/siso_shift_ctrl_if.sv
// Bus between a parallel producer/consumer, the serial line and the
// siso_shift_ctrl sequencer.
//
// Handshake: a word moves on a rising clk edge where in_valid and in_ready
// are both high. The source holds in_data stable and keeps in_valid high
// until that edge. in_ready never depends on in_valid. out_valid is a
// one-cycle strobe with no backpressure: the consumer must take out_data
// in that cycle or read it later, because it holds until the next word.
interface siso_shift_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              sin;
    logic              sout;
    logic              shift_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;

    // Producer / serial environment side.
    modport master (
        output in_data,
        output in_valid,
        output sin,
        input  in_ready,
        input  sout,
        input  shift_en,
        input  out_data,
        input  out_valid,
        input  busy
    );

    // Controller side.
    modport slave (
        input  in_data,
        input  in_valid,
        input  sin,
        output in_ready,
        output sout,
        output shift_en,
        output out_data,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/siso_shift_ctrl.sv
// Serial-in/serial-out shift sequencer. It accepts a parallel word, then
// shifts it out on sout one bit every DIV clocks. In the same bit periods it
// shifts sin in, and it presents the received word with a one-cycle
// out_valid strobe. shift_en marks the last clock of each bit period, which
// is the edge where both shift registers move.
module siso_shift_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    siso_shift_ctrl_if.slave bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int OUT_IDX = (LSB_FIRST != 0) ? 0 : DATA_W - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-1:0] rx_reg;
    logic [DATA_W-1:0] out_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt;

    logic              ready_int;
    logic              accept;
    logic              bit_end;
    logic              last_bit;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;

    // An accept is blocked during reset, so reset wins over a waiting word.
    assign ready_int = (state == IDLE) && !rst;
    assign accept    = bus.in_valid && ready_int;

    // The last clock of a bit period. Both shift registers move on this edge.
    assign bit_end  = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign last_bit = bit_end && (bit_cnt == BIT_LAST);

    // Shift direction: tx moves toward the output end with zero fill. rx
    // takes sin at the end opposite to where the first bit will settle. This
    // makes a loopback return the original word for either bit order.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign tx_shifted = {1'b0, tx_reg[DATA_W-1:1]};
            assign rx_shifted = {bus.sin, rx_reg[DATA_W-1:1]};
        end else begin : g_msb_first
            assign tx_shifted = {tx_reg[DATA_W-2:0], 1'b0};
            assign rx_shifted = {rx_reg[DATA_W-2:0], bus.sin};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, then divide and shift while in SHIFT.
    // The received word goes to out_q together with its final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg  <= '0;
            rx_reg  <= '0;
            out_q   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                tx_reg  <= bus.in_data;
                rx_reg  <= '0;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                if (bit_end) begin
                    div_cnt <= '0;
                    tx_reg  <= tx_shifted;
                    rx_reg  <= rx_shifted;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        out_q <= rx_shifted;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    // Output decode. sout comes straight from the tx register, so it only
    // changes at bit boundaries. It is forced low outside SHIFT.
    always_comb begin
        bus.in_ready  = ready_int;
        bus.sout      = (state == SHIFT) ? tx_reg[OUT_IDX] : 1'b0;
        bus.shift_en  = bit_end;
        bus.out_data  = out_q;
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        dbg_state     = state;
    end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl. dut_a uses the defaults
// (8 bits, DIV=4, MSB first). dut_b uses LSB first with DIV=1 and has its
// serial line looped back.
module tb_siso_shift_ctrl;

    logic clk;
    logic rst;

    siso_shift_ctrl_if #(.DATA_W(8)) a_if ();
    siso_shift_ctrl_if #(.DATA_W(8)) b_if ();

    logic [1:0] a_state;
    logic [1:0] b_state;
    bit         a_loop;
    logic       a_sin;

    siso_shift_ctrl #(.DATA_W(8), .DIV(4), .LSB_FIRST(0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (a_if.slave),
        .dbg_state (a_state)
    );

    siso_shift_ctrl #(.DATA_W(8), .DIV(1), .LSB_FIRST(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (b_if.slave),
        .dbg_state (b_state)
    );

    assign a_if.sin = a_loop ? a_if.sout : a_sin;
    assign b_if.sin = b_if.sout;

    // Clock / reset-free clock generator.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total  = 0;
    int bad    = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard for dut_a: every out_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (a_if.out_valid === 1'b1) begin
            ov_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_out_valid at %0t: got 1 expected 0", $time);
            end else begin
                chk("a_scoreboard", {24'd0, a_if.out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Full dut_a transfer, checked cycle by cycle. Call at a negedge with the DUT idle.
    task automatic send_a(input logic [7:0] d, input logic [7:0] exp);
        int p0;
        int k;
        chk("a_ready_before", {31'd0, a_if.in_ready}, 32'd1);
        a_if.in_data  = d;
        a_if.in_valid = 1'b1;
        exp_q.push_back(exp);
        p0 = ov_cnt;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            a_if.in_valid = 1'b0;
            k = (c - 1) / 4;
            chk("a_sout", {31'd0, a_if.sout}, {31'd0, d[7-k]});
            chk("a_shift_en", {31'd0, a_if.shift_en}, {31'd0, (c % 4) == 0});
            chk("a_ready_busy", {31'd0, a_if.in_ready}, 32'd0);
            chk("a_busy", {31'd0, a_if.busy}, 32'd1);
            chk("a_out_valid_early", {31'd0, a_if.out_valid}, 32'd0);
            if (c == 1) chk("a_state_shift", {30'd0, a_state}, 32'd1);
        end
        @(negedge clk);
        chk("a_out_valid", {31'd0, a_if.out_valid}, 32'd1);
        chk("a_out_data", {24'd0, a_if.out_data}, {24'd0, exp});
        chk("a_done_sout", {31'd0, a_if.sout}, 32'd0);
        chk("a_done_ready", {31'd0, a_if.in_ready}, 32'd0);
        chk("a_done_busy", {31'd0, a_if.busy}, 32'd1);
        @(negedge clk);
        chk("a_ready_after", {31'd0, a_if.in_ready}, 32'd1);
        chk("a_busy_after", {31'd0, a_if.busy}, 32'd0);
        chk("a_out_valid_after", {31'd0, a_if.out_valid}, 32'd0);
        chk("a_pulse_count", ov_cnt, p0 + 1);
    endtask

    typedef struct {
        logic [7:0] din;
        bit         loop;
        logic       sin_val;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Driver sequence: reset, vector table, then multi-cycle corner cases.
    initial begin
        logic [7:0] bw;
        logic [7:0] b_words[2];

        vecs[0] = '{din: 8'hA5, loop: 1'b1, sin_val: 1'b0, exp: 8'hA5};
        vecs[1] = '{din: 8'h00, loop: 1'b0, sin_val: 1'b1, exp: 8'hFF};
        vecs[2] = '{din: 8'hFF, loop: 1'b0, sin_val: 1'b0, exp: 8'h00};
        vecs[3] = '{din: 8'h81, loop: 1'b1, sin_val: 1'b0, exp: 8'h81};
        vecs[4] = '{din: 8'h0F, loop: 1'b1, sin_val: 1'b0, exp: 8'h0F};
        vecs[5] = '{din: 8'h6C, loop: 1'b0, sin_val: 1'b1, exp: 8'hFF};
        b_words[0] = 8'h01;
        b_words[1] = 8'hB4;

        // Reset held for two edges with a word offered: nothing may start.
        rst           = 1'b1;
        a_loop        = 1'b1;
        a_sin         = 1'b0;
        a_if.in_data  = 8'hFF;
        a_if.in_valid = 1'b1;
        b_if.in_data  = 8'h00;
        b_if.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_ready", {31'd0, a_if.in_ready}, 32'd0);
            chk("rst_sout", {31'd0, a_if.sout}, 32'd0);
            chk("rst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
            chk("rst_busy", {31'd0, a_if.busy}, 32'd0);
            chk("rst_shift_en", {31'd0, a_if.shift_en}, 32'd0);
            chk("rst_out_data", {24'd0, a_if.out_data}, 32'd0);
            chk("rst_state", {30'd0, a_state}, 32'd0);
            chk("rst_b_in_ready", {31'd0, b_if.in_ready}, 32'd0);
        end
        rst           = 1'b0;
        a_if.in_valid = 1'b0;
        #1;
        chk("rel_in_ready", {31'd0, a_if.in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rel_no_start", {31'd0, a_if.busy}, 32'd0);
        end

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            a_loop = vecs[v].loop;
            a_sin  = vecs[v].sin_val;
            send_a(vecs[v].din, vecs[v].exp);
        end

        // Back-to-back words with in_valid held high throughout.
        a_loop        = 1'b1;
        a_if.in_data  = 8'h3C;
        a_if.in_valid = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) a_if.in_data = 8'hC3;
            chk("b2b_ready_low", {31'd0, a_if.in_ready}, 32'd0);
        end
        @(negedge clk);
        chk("b2b_ready_again", {31'd0, a_if.in_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_second_busy", {31'd0, a_if.busy}, 32'd1);
        chk("b2b_second_ready", {31'd0, a_if.in_ready}, 32'd0);
        a_if.in_valid = 1'b0;
        repeat (33) @(negedge clk);
        chk("b2b_queue_empty", exp_q.size(), 32'd0);
        chk("b2b_idle", {31'd0, a_if.in_ready}, 32'd1);

        // Reset after the third shift_en of 0x5A aborts the word.
        chk("abort_prev_data", {24'd0, a_if.out_data}, 32'h0000_00C3);
        a_if.in_data  = 8'h5A;
        a_if.in_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            a_if.in_valid = 1'b0;
        end
        chk("abort_third_pulse", {31'd0, a_if.shift_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, a_if.busy}, 32'd0);
        chk("abort_out_data", {24'd0, a_if.out_data}, 32'd0);
        chk("abort_out_valid", {31'd0, a_if.out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'd0, a_if.in_ready}, 32'd1);
        @(negedge clk);
        chk("abort_stay_idle", {31'd0, a_if.busy}, 32'd0);
        send_a(8'h81, 8'h81);

        // dut_b: LSB first, one clock per bit, loopback.
        for (int w = 0; w < 2; w++) begin
            bw = b_words[w];
            chk("b_ready_before", {31'd0, b_if.in_ready}, 32'd1);
            b_if.in_data  = bw;
            b_if.in_valid = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                b_if.in_valid = 1'b0;
                chk("b_sout", {31'd0, b_if.sout}, {31'd0, bw[c-1]});
                chk("b_shift_en", {31'd0, b_if.shift_en}, 32'd1);
                chk("b_busy", {31'd0, b_if.busy}, 32'd1);
                chk("b_out_valid_early", {31'd0, b_if.out_valid}, 32'd0);
            end
            @(negedge clk);
            chk("b_out_valid", {31'd0, b_if.out_valid}, 32'd1);
            chk("b_out_data", {24'd0, b_if.out_data}, {24'd0, bw});
            chk("b_done_shift_en", {31'd0, b_if.shift_en}, 32'd0);
            chk("b_done_state", {30'd0, b_state}, 32'd2);
            @(negedge clk);
            chk("b_ready_after", {31'd0, b_if.in_ready}, 32'd1);
            chk("b_out_valid_after", {31'd0, b_if.out_valid}, 32'd0);
        end

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
